// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: loads a program over valid/ready, then serves bytes at pc and halts on a stalled pc.
// Define IFETCH_CHECKSUM_EN to treat the loadLast byte as a mod-256 checksum of the stored program.
module instruction_fetch_unit #(
    parameter int DEPTH        = 256,
    parameter int STALL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadValid,
    input  logic [7:0] loadData,
    input  logic       loadLast,
    output logic       loadReady,
    input  logic       reload,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       instrValid,
    output logic       cpuReset,
    output logic       halted,
    output logic [8:0] progLen,
    output logic       loadErr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STALL_CYCLES);

    typedef enum logic [1:0] {LOAD, PRIME, RUN, HALT} state_t;
    state_t state, next_state;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] stall_cnt;
    logic [7:0]    prev_pc;
    logic          xfer, full, store, done, csum_bad, reload_go, same_pc, stall_hit;

    assign xfer      = loadValid && loadReady;
    assign full      = wr_ptr == AW'(DEPTH - 1);
    assign reload_go = reload && (state == RUN || state == HALT);
    assign same_pc   = pc == prev_pc;
    assign stall_hit = same_pc && stall_cnt == CW'(STALL_CYCLES - 2);

`ifdef IFETCH_CHECKSUM_EN
    logic [7:0] sum;
    logic       load_err;
    // The checksum byte itself is never stored; a memory-full slot skips the check.
    assign store    = xfer && !loadLast;
    assign csum_bad = xfer && loadLast && loadData != sum;
    assign done     = (xfer && loadLast && loadData == sum) || (store && full);
    assign loadErr  = load_err;
    always_ff @(posedge clk) begin
        if (reset || reload_go) begin
            sum      <= 8'h00;
            load_err <= 1'b0;
        end else if (csum_bad) begin
            sum      <= 8'h00;
            load_err <= 1'b1;
        end else if (xfer) begin
            sum      <= store ? sum + loadData : 8'h00;
            load_err <= 1'b0;
        end
    end
`else
    assign store    = xfer;
    assign csum_bad = 1'b0;
    assign done     = xfer && (loadLast || full);
    assign loadErr  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= LOAD;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:  next_state = done ? PRIME : LOAD;
            PRIME: next_state = RUN;
            RUN:   next_state = reload ? LOAD : stall_hit ? HALT : RUN;
            HALT:  next_state = reload ? LOAD : HALT;
        endcase
    end

    always_comb begin
        loadReady  = state == LOAD;
        cpuReset   = state == LOAD || state == PRIME;
        instrValid = state == RUN;
        halted     = state == HALT;
    end

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= loadData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            progLen     <= '0;
            instruction <= 8'h00;
            stall_cnt   <= '0;
            prev_pc     <= 8'h00;
        end else begin
            prev_pc <= pc;
            if (reload_go || csum_bad) begin
                wr_ptr  <= '0;
                progLen <= '0;
            end else if (store) begin
                wr_ptr  <= wr_ptr + AW'(1);
                progLen <= progLen + 9'd1;
            end
            // Counter stays frozen in HALT so the stall that caused it remains visible.
            if (state == RUN)
                stall_cnt <= same_pc ? stall_cnt + CW'(1) : '0;
            else if (state != HALT)
                stall_cnt <= '0;
            if (state == PRIME)
                instruction <= mem[0];
            else if (state == RUN && next_state == RUN)
                instruction <= ({1'b0, pc} < progLen) ? mem[pc[AW-1:0]] : 8'h00;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for load, prime, run, stall halt, reload and reset.
module tb_instruction_fetch_unit;
`ifdef IFETCH_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    logic       clk = 1'b0, reset = 1'b1, loadValid = 1'b0, loadLast = 1'b0, reload = 1'b0;
    logic [7:0] loadData = 8'h00, pc = 8'h00;
    logic       loadReady, instrValid, cpuReset, halted, loadErr;
    logic [7:0] instruction;
    logic [8:0] progLen;
    int         errors = 0, checks = 0;
    logic [7:0] model [256];
    int         model_len = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .loadValid(loadValid), .loadData(loadData),
        .loadLast(loadLast), .loadReady(loadReady), .reload(reload), .pc(pc),
        .instruction(instruction), .instrValid(instrValid), .cpuReset(cpuReset),
        .halted(halted), .progLen(progLen), .loadErr(loadErr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expect_instr(input logic [7:0] p);
        return (int'(p) < model_len) ? model[p] : 8'h00;
    endfunction

    task automatic run_pc(input logic [7:0] p);
        pc = p;
        sb.push_back(expect_instr(p));
        tick;
        chk("instr", instruction, sb.pop_front());
        chk("valid", instrValid, 1);
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        loadValid = 1'b1;
        loadData  = d;
        loadLast  = last;
        tick;
        loadValid = 1'b0;
        loadLast  = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_ready", loadReady, 1);
        chk("rst_cpurst", cpuReset, 1);
        chk("rst_valid", instrValid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_len", progLen, 0);
        chk("rst_instr", instruction, 8'h00);
        chk("rst_err", loadErr, 0);
        reset = 1'b0;

        model[0] = 8'h41; model[1] = 8'h82; model[2] = 8'hC3;
        model_len = CS ? 2 : 3;
        load_byte(8'h41, 0);
        load_byte(8'h82, 0);
        load_byte(8'hC3, 1);
        chk("prime_len", progLen, 9'(model_len));
        chk("prime_cpurst", cpuReset, 1);
        chk("prime_ready", loadReady, 0);
        chk("prime_valid", instrValid, 0);
        chk("prime_err", loadErr, 0);
        pc = 8'h00;
        tick;
        chk("run_cpurst", cpuReset, 0);
        chk("run_valid", instrValid, 1);
        chk("run_instr0", instruction, 8'h41);

        run_pc(0); run_pc(1); run_pc(2); run_pc(5);
        run_pc(7); run_pc(7); run_pc(7); run_pc(3); run_pc(3); run_pc(3);
        chk("no_halt", halted, 0);
        run_pc(2); run_pc(2); run_pc(2);
        chk("pre_halt", halted, 0);
        pc = 8'h02;
        tick;
        chk("halt", halted, 1);
        chk("halt_valid", instrValid, 0);
        chk("halt_cpurst", cpuReset, 0);
        chk("halt_instr", instruction, expect_instr(2));
        pc = 8'h09;
        tick;
        tick;
        chk("halt_stay", halted, 1);
        chk("halt_hold", instruction, expect_instr(2));

        reload = 1'b1;
        tick;
        reload = 1'b0;
        chk("rl_halted", halted, 0);
        chk("rl_cpurst", cpuReset, 1);
        chk("rl_len", progLen, 0);
        chk("rl_ready", loadReady, 1);
        reload = 1'b1;
        tick;
        reload = 1'b0;
        chk("rl_load_ign", loadReady, 1);
        chk("rl_load_cpurst", cpuReset, 1);

        load_byte(8'h01, 0);
        load_byte(8'h02, 0);
        chk("part_len", progLen, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_mid_len", progLen, 0);
        chk("rst_mid_ready", loadReady, 1);

        for (int i = 0; i < 256; i++) begin
            model[i] = 8'(i * 7 + 3);
            load_byte(model[i], 0);
            if (i == 254) begin
                chk("full_m1_ready", loadReady, 1);
                chk("full_m1_len", progLen, 255);
            end
        end
        model_len = 256;
        chk("full_len", progLen, 256);
        chk("full_ready", loadReady, 0);
        chk("full_cpurst", cpuReset, 1);
        pc = 8'h00;
        tick;
        chk("full_instr0", instruction, model[0]);
        for (int k = 0; k < 20; k++)
            run_pc(8'(k * 53 + 255));

        run_pc(4); run_pc(4); run_pc(4);
        pc = 8'h04;
        reload = 1'b1;
        tick;
        reload = 1'b0;
        chk("rl_dom_halted", halted, 0);
        chk("rl_dom_ready", loadReady, 1);
        chk("rl_dom_cpurst", cpuReset, 1);

`ifdef IFETCH_CHECKSUM_EN
        load_byte(8'h10, 0);
        load_byte(8'h20, 0);
        load_byte(8'h30, 1);
        chk("cs_ok_len", progLen, 2);
        chk("cs_ok_ready", loadReady, 0);
        chk("cs_ok_err", loadErr, 0);
        tick;
        reload = 1'b1;
        tick;
        reload = 1'b0;
        load_byte(8'h10, 0);
        load_byte(8'h20, 0);
        load_byte(8'h31, 1);
        chk("cs_bad_err", loadErr, 1);
        chk("cs_bad_ready", loadReady, 1);
        chk("cs_bad_len", progLen, 0);
        load_byte(8'h55, 0);
        chk("cs_clr_err", loadErr, 0);
        chk("cs_clr_len", progLen, 1);
`else
        chk("err_tied", loadErr, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream stage of the 8-bit microprocessor. It loads a program byte-stream into local instruction memory over a valid/ready handshake, then serves instruction bytes addressed by the processor's nextPc. It holds the processor in reset while loading, and detects a stalled PC (self-branch) to halt fetch.

Parameters:
DEPTH, 256, instruction memory entries; the address is the low log2(DEPTH) bits of pc, and DEPTH must be ≤256.
STALL_CYCLES, 4, number of consecutive cycles with an unchanged pc that triggers HALT (≥2).

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
loadValid  in  1  loadData is presented
loadData  in  8  program byte
loadLast  in  1  qualifies the final byte of the program (sampled with loadValid)
loadReady  out  1  unit accepts a byte this cycle
reload  in  1  abort run and return to LOAD
pc  in  8  nextPc from the processor
instruction  out  8  instruction byte for the processor
instrValid  out  1  instruction is a fetched program byte
cpuReset  out  1  reset to drive into the processor
halted  out  1  stall-detected flag
progLen  out  9  number of stored program bytes
loadErr  out  1  checksum failure (see Optional Feature)

Behaviour:
- FSM states: LOAD, PRIME, RUN, HALT.
- Reset values: state=LOAD, wrPtr=0, progLen=0, instruction=8'h00, instrValid=0, cpuReset=1, halted=0, loadErr=0, stall counter=0. Memory contents are not cleared.
- LOAD:
  - loadReady=1, cpuReset=1, instrValid=0.
  - A byte transfers when loadValid && loadReady: mem[wrPtr]<=loadData, wrPtr++, progLen++.
  - Go to PRIME on a transfer with loadLast=1, or on a transfer at wrPtr==DEPTH-1 (memory full, implicit last). No wrap-around.
  - loadValid without a transfer has no effect.
- PRIME:
  - Lasts exactly 1 cycle; loadReady=0, cpuReset=1.
  - Registers instruction<=mem[0] and sets instrValid=1, so a valid instruction is present on the cycle cpuReset first reads 0.
- RUN:
  - cpuReset=0, loadReady=0.
  - Each cycle: instruction<=(pc<progLen ? mem[pc] : 8'h00). Latency is 1 cycle from pc to instruction.
  - pc≥progLen keeps instrValid=1 and outputs 8'h00.
  - Stall counter: counts cycles with pc equal to its value in the previous cycle; it clears on any change. When the counter reaches STALL_CYCLES-1, the next state is HALT.
- HALT:
  - halted=1, instrValid=0, instruction holds its last value, cpuReset=0 (processor state remains observable). The stall counter is frozen.
  - Only reset or reload leaves HALT.
- reload:
  - In RUN or HALT, the next state is LOAD with wrPtr=0, progLen=0, halted=0, loadErr=0, instrValid=0, cpuReset=1.
  - reload in LOAD or PRIME is ignored.
- Simultaneous events:
  - reset dominates everything.
  - reload dominates stall detection in the same cycle.
  - A loadLast transfer on the memory-full slot is one transition, not two.
- Reset mid-load discards the partial program; progLen returns to 0.

Optional Feature:
Macro IFETCH_CHECKSUM_EN.
- Defined:
  - The byte transferred with loadLast=1 is a checksum and is not stored; progLen is unchanged for it.
  - An 8-bit running sum (mod 256) of the stored bytes is compared against it. On a match, go to PRIME. On a mismatch, set loadErr=1, stay in LOAD, and reset wrPtr/progLen to 0. loadErr clears on the next accepted byte.
  - A memory-full implicit last skips the check and goes to PRIME.
- Undefined: the loadLast byte is stored as a normal program byte, and loadErr is tied to 0.

Test Plan:
- Reset, then load 3 bytes 8'h41,8'h82,8'hC3 (last on the third) -> progLen=3; PRIME for 1 cycle with instruction=8'h41 and cpuReset=1; cpuReset=0 the next cycle.
- RUN with pc=0,1,2,5 on consecutive cycles -> instruction=8'h41,8'h82,8'hC3,8'h00, each one cycle after its pc; instrValid=1 throughout.
- Hold pc=2 steady for 4 cycles -> halted=1 and instrValid=0 on the cycle after the 4th. A pc change at cycle 3 prevents HALT.
- Stream 256 bytes without loadLast -> PRIME entered after the 256th transfer; progLen=256; loadReady=0 afterwards.
- Assert reload in HALT -> next cycle state LOAD, cpuReset=1, halted=0, progLen=0; a reload pulse during LOAD is ignored. Assert reset mid-load after 2 bytes -> progLen=0.
- With IFETCH_CHECKSUM_EN: bytes 8'h10,8'h20, checksum 8'h30 -> PRIME, progLen=2. Checksum 8'h31 -> loadErr=1, still LOAD, progLen=0.
